// File: rtl/roberto_pkg.sv
// roberto_pkg: shared state codes, control bundle and defaults
// for the ultrasonic measurement/report control unit.
package roberto_pkg;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_PREPARA       = 4'd1,
    ST_ESPERA_SEG    = 4'd2,
    ST_MEDE          = 4'd3,
    ST_ESPERA_MEDIDA = 4'd4,
    ST_TRANSMITE     = 4'd5,
    ST_ESPERA_TX     = 4'd6,
    ST_PROX_CHAR     = 4'd7,
    ST_PROX_SENSOR   = 4'd8,
    ST_FIM_CICLO     = 4'd9
  } state_t;

  localparam logic [7:0] ASCII_HASH = 8'h23;

  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;

  typedef struct packed {
    logic zera_sensor;
    logic zera_serial;
    logic zera_seg;
    logic zera_2;
    logic zera_3;
    logic cont_seg;
    logic cont_2;
    logic cont_3;
    logic medir;
    logic partida_tx;
    logic pronto;
  } ctl_t;

endpackage

// File: rtl/roberto_timeout.sv
// roberto_timeout: saturating cycle counter with clear/enable;
// expired is high while the count sits at LIMIT-1.
module roberto_timeout #(
  parameter int LIMIT = 8,
  parameter int W     = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/roberto_uc.sv
// roberto_uc: control FSM for the 3-sensor measure/report datapath.
// ROBERTO_UC_TIMEOUT_EN enables the measurement timeout and erro_medida.
module roberto_uc
  import roberto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TW             = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ligar,
  input  logic       pronto_seg,
  input  logic       medida_pronto,
  input  logic       pronto_serial,
  input  logic       fim_char,
  input  logic       fim_sensor,
  output logic       zera_sensor,
  output logic       zera_serial,
  output logic       zera_seg,
  output logic       zera_2,
  output logic       zera_3,
  output logic       cont_seg,
  output logic       cont_2,
  output logic       cont_3,
  output logic       medir,
  output logic       partida_tx,
  output logic       pronto,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  state_t state;
  state_t state_nx;
  ctl_t   ctl;
  logic   tmo;

`ifdef ROBERTO_UC_TIMEOUT_EN
  logic erro_q;

  roberto_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TW)
  ) u_tmo (
    .clk     (clock),
    .rst_n   (reset_n),
    .clr     (state == ST_MEDE),
    .en      (state == ST_ESPERA_MEDIDA),
    .expired (tmo)
  );

  // A reply arriving in the expiry cycle is a success, not an error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      erro_q <= 1'b0;
    end else if (state_nx == ST_PREPARA) begin
      erro_q <= 1'b0;
    end else if (state == ST_ESPERA_MEDIDA && ligar
                 && !medida_pronto && tmo) begin
      erro_q <= 1'b1;
    end
  end

  assign erro_medida = erro_q;
`else
  logic unused_cfg;

  assign tmo         = 1'b0;
  assign erro_medida = 1'b0;
  assign unused_cfg  = ^{TIMEOUT_CYCLES[0], TW[0]};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ctl      = '0;
    case (state)
      ST_IDLE: begin
        if (ligar) state_nx = ST_PREPARA;
      end
      ST_PREPARA: begin
        ctl.zera_sensor = 1'b1;
        ctl.zera_serial = 1'b1;
        ctl.zera_seg    = 1'b1;
        ctl.zera_2      = 1'b1;
        ctl.zera_3      = 1'b1;
        state_nx = ligar ? ST_ESPERA_SEG : ST_IDLE;
      end
      ST_ESPERA_SEG: begin
        ctl.cont_seg = 1'b1;
        if (!ligar)          state_nx = ST_IDLE;
        else if (pronto_seg) state_nx = ST_MEDE;
      end
      ST_MEDE: begin
        ctl.medir = 1'b1;
        state_nx = ligar ? ST_ESPERA_MEDIDA : ST_IDLE;
      end
      ST_ESPERA_MEDIDA: begin
        if (!ligar)                    state_nx = ST_IDLE;
        else if (medida_pronto || tmo) state_nx = ST_TRANSMITE;
      end
      ST_TRANSMITE: begin
        ctl.partida_tx = 1'b1;
        state_nx = ST_ESPERA_TX;
      end
      // The character in flight always finishes before ligar is honoured.
      ST_ESPERA_TX: begin
        if (pronto_serial) begin
          if (!ligar)           state_nx = ST_IDLE;
          else if (!fim_char)   state_nx = ST_PROX_CHAR;
          else if (!fim_sensor) state_nx = ST_PROX_SENSOR;
          else                  state_nx = ST_FIM_CICLO;
        end
      end
      ST_PROX_CHAR: begin
        ctl.cont_2 = 1'b1;
        state_nx = ligar ? ST_TRANSMITE : ST_IDLE;
      end
      ST_PROX_SENSOR: begin
        ctl.zera_2 = 1'b1;
        ctl.cont_3 = 1'b1;
        state_nx = ligar ? ST_TRANSMITE : ST_IDLE;
      end
      ST_FIM_CICLO: begin
        ctl.zera_2   = 1'b1;
        ctl.zera_3   = 1'b1;
        ctl.zera_seg = 1'b1;
        ctl.pronto   = 1'b1;
        state_nx = ligar ? ST_ESPERA_SEG : ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign zera_sensor = ctl.zera_sensor;
  assign zera_serial = ctl.zera_serial;
  assign zera_seg    = ctl.zera_seg;
  assign zera_2      = ctl.zera_2;
  assign zera_3      = ctl.zera_3;
  assign cont_seg    = ctl.cont_seg;
  assign cont_2      = ctl.cont_2;
  assign cont_3      = ctl.cont_3;
  assign medir       = ctl.medir;
  assign partida_tx  = ctl.partida_tx;
  assign pronto      = ctl.pronto;
  assign db_estado   = state;

endmodule

// File: tb/tb_roberto_uc.sv
// tb_roberto_uc: randomized frames against a behavioural datapath
// model; expectations come from frame arithmetic.
module tb_roberto_uc;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ligar = 1'b0;
  logic pronto_seg = 1'b0;
  logic medida_pronto = 1'b0;
  logic pronto_serial = 1'b0;
  logic fim_char = 1'b0;
  logic fim_sensor = 1'b0;
  logic zera_sensor, zera_serial, zera_seg, zera_2, zera_3;
  logic cont_seg, cont_2, cont_3, medir, partida_tx, pronto;
  logic erro_medida;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  roberto_uc #(
    .TIMEOUT_CYCLES (8),
    .TW             (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ligar         (ligar),
    .pronto_seg    (pronto_seg),
    .medida_pronto (medida_pronto),
    .pronto_serial (pronto_serial),
    .fim_char      (fim_char),
    .fim_sensor    (fim_sensor),
    .zera_sensor   (zera_sensor),
    .zera_serial   (zera_serial),
    .zera_seg      (zera_seg),
    .zera_2        (zera_2),
    .zera_3        (zera_3),
    .cont_seg      (cont_seg),
    .cont_2        (cont_2),
    .cont_3        (cont_3),
    .medir         (medir),
    .partida_tx    (partida_tx),
    .pronto        (pronto),
    .erro_medida   (erro_medida),
    .db_estado     (db_estado)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // Environment: period P, meas delay M (0 = never),
  // N chars x S sensors, T cycles per character.
  int P = 1, M = 1, N = 1, S = 1, T = 1;
  int ci = 0, si = 0, sc = 0, mc = 0, tc = 0;
  bit mact = 0, tact = 0;

  int n_zs, n_cs, n_c2, n_c3, n_med, n_ptx, n_pr, n_w4;
  int med_cyc, pr_cyc, ps_cyc, lig_cyc;
  bit ps_pend = 0, post_fim = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {zera_sensor, zera_serial, zera_seg, zera_2, zera_3,
            cont_seg, cont_2, cont_3, medir, partida_tx,
            pronto, erro_medida};
  endfunction

  task automatic clr_cnt();
    n_zs = 0; n_cs = 0; n_c2 = 0; n_c3 = 0;
    n_med = 0; n_ptx = 0; n_pr = 0; n_w4 = 0;
    med_cyc = 0; pr_cyc = 0;
  endtask

  task automatic clr_env();
    ci = 0; si = 0; sc = 0; mc = 0; tc = 0;
    mact = 0; tact = 0; ps_pend = 0; post_fim = 0;
    pronto_seg = 0; medida_pronto = 0; pronto_serial = 0;
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
    if (post_fim) begin
      post_fim = 0;
      check("after_fim", 32'(db_estado), ligar ? 2 : 0);
    end
    n_zs  += int'(zera_sensor);
    n_cs  += int'(cont_seg);
    n_c2  += int'(cont_2);
    n_c3  += int'(cont_3);
    n_med += int'(medir);
    n_ptx += int'(partida_tx);
    n_pr  += int'(pronto);
    if (db_estado == 4'd4) n_w4++;
    if (medir) med_cyc = cyc;
    if (pronto) begin
      pr_cyc = cyc;
      post_fim = 1;
    end
    if (partida_tx && ps_pend) begin
      check("ps_to_tx", cyc - ps_cyc, 2);
      ps_pend = 0;
    end
    if (zera_2) ci = 0; else if (cont_2) ci++;
    if (zera_3) si = 0; else if (cont_3) si++;
    fim_char   = (ci == N - 1);
    fim_sensor = (si == S - 1);
    if (cont_seg) begin
      sc++;
      pronto_seg = (sc == P);
    end else begin
      sc = 0;
      pronto_seg = 0;
    end
    medida_pronto = 0;
    if (zera_sensor) begin
      mact = 0;
    end else if (medir) begin
      mact = 1;
      mc = 0;
    end else if (mact) begin
      mc++;
      if (M != 0 && mc == M) begin
        medida_pronto = 1;
        mact = 0;
      end
    end
    pronto_serial = 0;
    if (partida_tx) begin
      tact = 1;
      tc = 0;
    end else if (tact) begin
      tc++;
      if (tc == T) begin
        pronto_serial = 1;
        tact = 0;
        ps_cyc = cyc;
        ps_pend = ligar && !(fim_char && fim_sensor);
      end
    end
  endtask

  task automatic wait_state(input string tag, input int st,
                            input int budget);
    for (int i = 0; i < budget && db_estado != 4'(st); i++) step();
    check(tag, 32'(db_estado), st);
  endtask

  task automatic run_frame(input string tag,
                           input int p, input int m, input int mw,
                           input int n, input int s, input int t,
                           input bit from_idle, input bit exp_err);
    int len;
    P = p; M = m; N = n; S = s; T = t;
    clr_cnt();
    if (from_idle) begin
      ligar = 1;
      lig_cyc = cyc;
    end
    for (int i = 0; i < 5000 && n_pr == 0; i++) step();
    len = 1 + mw + n * s * (1 + t) + (n * s - 1) + 1;
    check({tag, "_pronto"}, n_pr, 1);
    check({tag, "_ptx"}, n_ptx, n * s);
    check({tag, "_cont2"}, n_c2, (n - 1) * s);
    check({tag, "_cont3"}, n_c3, s - 1);
    check({tag, "_contseg"}, n_cs, p);
    check({tag, "_medir"}, n_med, 1);
    check({tag, "_zera"}, n_zs, from_idle ? 1 : 0);
    check({tag, "_wait4"}, n_w4, mw);
    check({tag, "_len"}, pr_cyc - med_cyc + 1, len);
    check({tag, "_erro"}, 32'(erro_medida), 32'(exp_err));
    if (from_idle) check({tag, "_lat"}, med_cyc - lig_cyc, 2 + p);
  endtask

  initial begin
    int p, m, n, s, t, save;
    clr_env();
    clr_cnt();
    reset_n = 0;
    ligar = 0;
    repeat (3) step();
    check("rst_hold_st", 32'(db_estado), 0);
    check("rst_hold_out", 32'(outs()), 0);
    reset_n = 1;
    repeat (10) step();
    check("idle_st", 32'(db_estado), 0);
    check("idle_out", 32'(outs()), 0);

    run_frame("dir", 5, 3, 3, 4, 3, 4, 1, 0);

    for (int k = 0; k < 5; k++) begin
      p = $urandom_range(1, 6);
      m = $urandom_range(1, 6);
      n = $urandom_range(1, 4);
      s = $urandom_range(1, 3);
      t = $urandom_range(1, 5);
      run_frame($sformatf("rnd%0d", k), p, m, m, n, s, t, 0, 0);
    end

`ifdef ROBERTO_UC_TIMEOUT_EN
    run_frame("tie", 2, 8, 8, 1, 1, 1, 0, 0);
    run_frame("tmo", 3, 0, 8, 2, 2, 2, 0, 1);
    ligar = 0;
    step();
    check("err_hold", 32'(erro_medida), 1);
`else
    P = 2; M = 0;
    wait_state("wait_st4", 4, 100);
    repeat (50) step();
    check("no_tmo_st", 32'(db_estado), 4);
    check("no_tmo_err", 32'(erro_medida), 0);
    ligar = 0;
    step();
    check("drop_meas", 32'(db_estado), 0);
`endif

    P = 3; M = 2; N = 3; S = 2; T = 4;
    clr_cnt();
    ligar = 1;
    wait_state("drop_seg", 2, 20);
    check("err_clr", 32'(erro_medida), 0);
    for (int i = 0; i < 500 && !(n_ptx >= 2 && db_estado == 4'd6); i++)
      step();
    check("drop_tx_st", 32'(db_estado), 6);
    ligar = 0;
    for (int i = 0; i < 20 && !pronto_serial; i++) step();
    check("drop_ps", 32'(pronto_serial), 1);
    step();
    check("drop_idle", 32'(db_estado), 0);
    save = n_ptx;
    repeat (10) step();
    check("drop_no_tx", n_ptx, save);
    check("drop_still", 32'(db_estado), 0);

    P = 2; M = 0; N = 2; S = 1; T = 2;
    ligar = 1;
    wait_state("rst_st4", 4, 50);
    repeat (3) step();
    #2 reset_n = 0;
    #1;
    check("arst_st", 32'(db_estado), 0);
    check("arst_out", 32'(outs()), 0);
    check("arst_err", 32'(erro_medida), 0);
    ligar = 0;
    clr_env();
    repeat (2) step();
    reset_n = 1;
    repeat (3) step();
    check("arst_idle", 32'(db_estado), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
